// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared states, panel geometry and command tables for the OLED sequencer
package oled_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_RST_WAKE,
    ST_INIT,
    ST_IDLE,
    ST_WINDOW,
    ST_FETCH,
    ST_LOAD,
    ST_SEND
  } oled_state_t;

  localparam int CNT_W       = 14;
  localparam int INIT_LEN    = 25;
  localparam int WINDOW_LEN  = 6;
  localparam int CMD_ROM_LEN = INIT_LEN + WINDOW_LEN;
  localparam int OLED_PAGES  = 8;
  localparam int OLED_COLS   = 128;

  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
    8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
    8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

  // Full-screen column range 0..127, page range 0..7
  localparam logic [7:0] WINDOW_ROM [WINDOW_LEN] = '{
    8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
  };

  function automatic logic [9:0] fb_index(input logic [2:0] page, input logic [6:0] col);
    return {page, col};
  endfunction

endpackage

// File: rtl/oled_sequencer_if.sv
// rtl/oled_sequencer_if.sv - byte stream towards the serializer plus framebuffer read port
interface oled_sequencer_if;
  logic [7:0] byte_data;
  logic       byte_dc;
  logic       byte_valid;
  logic       byte_ready;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;

  modport master (
    output byte_data, byte_dc, byte_valid, fb_addr,
    input  byte_ready, fb_data
  );

  modport slave (
    input  byte_data, byte_dc, byte_valid, fb_addr,
    output byte_ready, fb_data
  );
endinterface

// File: rtl/oled_cmd_rom.sv
// rtl/oled_cmd_rom.sv - combinational lookup over the init table followed by the window table
module oled_cmd_rom
  import oled_pkg::*;
(
  input  logic [4:0] i_idx,
  output logic [7:0] o_byte
);

  logic [2:0] w_win_idx;

  assign w_win_idx = 3'(i_idx - 5'(INIT_LEN));

  always_comb begin
    o_byte = 8'h00;
    if (i_idx < 5'(INIT_LEN)) begin
      o_byte = INIT_ROM[i_idx];
    end else if (i_idx < 5'(CMD_ROM_LEN)) begin
      o_byte = WINDOW_ROM[w_win_idx];
    end
  end

endmodule

// File: rtl/oled_sequencer.sv
// rtl/oled_sequencer.sv - panel reset, init command stream and full-frame refresh sequencer
module oled_sequencer
  import oled_pkg::*;
#(
  parameter int RESET_CYCLES = 8334,
  parameter int WAKE_CYCLES  = 8334
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_req,
  oled_sequencer_if.master bus,
  output logic             oled_res_n,
  output logic             init_done,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [4:0]       C_INIT_LAST = 5'(INIT_LEN - 1);
  localparam logic [4:0]       C_WIN_LAST  = 5'(CMD_ROM_LEN - 1);
  localparam logic [2:0]       C_PAGE_LAST = 3'(OLED_PAGES - 1);
  localparam logic [6:0]       C_COL_LAST  = 7'(OLED_COLS - 1);

  oled_state_t      r_state,      w_state;
  logic [CNT_W-1:0] r_cnt,        w_cnt;
  logic [4:0]       r_idx,        w_idx;
  logic [2:0]       r_page,       w_page;
  logic [6:0]       r_col,        w_col;
  logic [7:0]       r_byte_data,  w_byte_data;
  logic             r_byte_dc,    w_byte_dc;
  logic             r_byte_valid, w_byte_valid;
  logic [9:0]       r_fb_addr,    w_fb_addr;
  logic             r_res_n,      w_res_n;
  logic             r_init_done,  w_init_done;
  logic             r_frame_done, w_frame_done;
  logic             r_pending,    w_pending;

  logic             w_xfer;
  logic [4:0]       w_rom_idx;
  logic [7:0]       w_rom_byte;

  assign w_xfer = r_byte_valid & bus.byte_ready;

  // ROM address points at the byte to present after the current edge
  always_comb begin
    case (r_state)
      ST_RST_WAKE: w_rom_idx = 5'd0;
      ST_IDLE:     w_rom_idx = 5'(INIT_LEN);
      default:     w_rom_idx = r_idx + 5'd1;
    endcase
  end

  oled_cmd_rom u_rom (
    .i_idx  (w_rom_idx),
    .o_byte (w_rom_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RST_HOLD;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_page       <= '0;
      r_col        <= '0;
      r_byte_data  <= 8'h00;
      r_byte_dc    <= 1'b0;
      r_byte_valid <= 1'b0;
      r_fb_addr    <= '0;
      r_res_n      <= 1'b0;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_pending    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_idx        <= w_idx;
      r_page       <= w_page;
      r_col        <= w_col;
      r_byte_data  <= w_byte_data;
      r_byte_dc    <= w_byte_dc;
      r_byte_valid <= w_byte_valid;
      r_fb_addr    <= w_fb_addr;
      r_res_n      <= w_res_n;
      r_init_done  <= w_init_done;
      r_frame_done <= w_frame_done;
      r_pending    <= w_pending;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_idx        = r_idx;
    w_page       = r_page;
    w_col        = r_col;
    w_byte_data  = r_byte_data;
    w_byte_dc    = r_byte_dc;
    w_byte_valid = r_byte_valid;
    w_fb_addr    = r_fb_addr;
    w_res_n      = r_res_n;
    w_init_done  = r_init_done;
    w_frame_done = 1'b0;
    // Requests outside IDLE collapse into a single pending refresh
    w_pending    = r_pending | frame_req;

    case (r_state)
      ST_RST_HOLD: begin
        if (r_cnt == C_HOLD_LAST) begin
          w_cnt   = '0;
          w_res_n = 1'b1;
          w_state = ST_RST_WAKE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      ST_RST_WAKE: begin
        if (r_cnt == C_WAKE_LAST) begin
          w_cnt        = '0;
          w_idx        = 5'd0;
          w_byte_data  = w_rom_byte;
          w_byte_dc    = 1'b0;
          w_byte_valid = 1'b1;
          w_state      = ST_INIT;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      ST_INIT: begin
        if (w_xfer) begin
          if (r_idx == C_INIT_LAST) begin
            w_byte_valid = 1'b0;
            w_init_done  = 1'b1;
            w_state      = ST_IDLE;
          end else begin
            w_idx       = r_idx + 5'd1;
            w_byte_data = w_rom_byte;
          end
        end
      end

      ST_IDLE: begin
        w_pending = 1'b0;
        if (frame_req || r_pending) begin
          w_idx        = 5'(INIT_LEN);
          w_byte_data  = w_rom_byte;
          w_byte_dc    = 1'b0;
          w_byte_valid = 1'b1;
          w_state      = ST_WINDOW;
        end
      end

      ST_WINDOW: begin
        if (w_xfer) begin
          if (r_idx == C_WIN_LAST) begin
            w_byte_valid = 1'b0;
            w_page       = 3'd0;
            w_col        = 7'd0;
            w_fb_addr    = fb_index(3'd0, 7'd0);
            w_state      = ST_FETCH;
          end else begin
            w_idx       = r_idx + 5'd1;
            w_byte_data = w_rom_byte;
          end
        end
      end

      ST_FETCH: begin
        w_state = ST_LOAD;
      end

      ST_LOAD: begin
        w_byte_data  = bus.fb_data;
        w_byte_dc    = 1'b1;
        w_byte_valid = 1'b1;
        w_state      = ST_SEND;
      end

      ST_SEND: begin
        if (w_xfer) begin
          w_byte_valid = 1'b0;
          if (r_col == C_COL_LAST && r_page == C_PAGE_LAST) begin
            w_frame_done = 1'b1;
            w_state      = ST_IDLE;
          end else begin
            if (r_col == C_COL_LAST) begin
              w_col  = 7'd0;
              w_page = r_page + 3'd1;
            end else begin
              w_col = r_col + 7'd1;
            end
            w_fb_addr = fb_index(w_page, w_col);
            w_state   = ST_FETCH;
          end
        end
      end

      default: w_state = ST_RST_HOLD;
    endcase
  end

  assign bus.byte_data  = r_byte_data;
  assign bus.byte_dc    = r_byte_dc;
  assign bus.byte_valid = r_byte_valid;
  assign bus.fb_addr    = r_fb_addr;
  assign oled_res_n     = r_res_n;
  assign init_done      = r_init_done;
  assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_oled_sequencer.sv
// tb/tb_oled_sequencer.sv - self-checking bench for oled_sequencer
module tb_oled_sequencer;

  localparam int RST_CYC  = 10;
  localparam int WAKE_CYC = 5;
  localparam int BOUND    = 20000;

  logic clk;
  logic rst_n;
  logic frame_req;
  logic oled_res_n;
  logic init_done;
  logic frame_done;

  oled_sequencer_if bus ();

  oled_sequencer #(
    .RESET_CYCLES (RST_CYC),
    .WAKE_CYCLES  (WAKE_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_req  (frame_req),
    .bus        (bus),
    .oled_res_n (oled_res_n),
    .init_done  (init_done),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [1024];
  logic [8:0] obs [$];
  int         obs_cyc [$];
  logic [8:0] exp_q [$];
  int         cyc = 0;
  int         data_cnt = 0;
  int         done_cnt = 0;
  int         stall_viol = 0;
  int         stall_seen = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data;
  logic       prev_dc;
  bit         rdy_rand = 0;

  int init_tbl [25] = '{'hAE, 'hD5, 'h80, 'hA8, 'h3F, 'hD3, 'h00, 'h40, 'h8D,
                        'h14, 'h20, 'h00, 'hA1, 'hC8, 'hDA, 'h12, 'h81, 'hCF,
                        'hD9, 'hF1, 'hDB, 'h40, 'hA4, 'hA6, 'hAF};
  int win_tbl [6] = '{'h21, 'h00, 'h7F, 'h22, 'h00, 'h07};

  typedef struct {
    int cyc;
    int res_n;
    int valid;
    int data;
    int init_done;
  } rst_vec_t;
  rst_vec_t vecs [5];

  function automatic logic [7:0] pix(input int a);
    logic [9:0] ad;
    ad = 10'(a);
    return ad[7:0] ^ {ad[9:7], 5'b0};
  endfunction

  always @(posedge clk) bus.fb_data <= mem[bus.fb_addr];

  always @(posedge clk) begin
    #1;
    if (rdy_rand) bus.byte_ready = 1'($urandom_range(0, 1));
    else          bus.byte_ready = 1'b1;
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && !(bus.byte_valid && bus.byte_data == prev_data && bus.byte_dc == prev_dc))
        stall_viol++;
      if (bus.byte_valid && bus.byte_ready) begin
        obs.push_back({bus.byte_dc, bus.byte_data});
        obs_cyc.push_back(cyc);
        if (bus.byte_dc) data_cnt++;
      end
      prev_stall = bus.byte_valid && !bus.byte_ready;
      if (prev_stall) stall_seen++;
      prev_data = bus.byte_data;
      prev_dc   = bus.byte_dc;
      if (frame_done) done_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void exp_init();
    foreach (init_tbl[i]) exp_q.push_back({1'b0, 8'(init_tbl[i])});
  endfunction

  function automatic void exp_frame();
    foreach (win_tbl[i]) exp_q.push_back({1'b0, 8'(win_tbl[i])});
    for (int a = 0; a < 1024; a++) exp_q.push_back({1'b1, pix(a)});
  endfunction

  task automatic check_stream(input string name);
    int bad = -1;
    if (obs.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++)
        if (bad < 0 && obs[i] !== exp_q[i]) bad = i;
    end
    check({name, "_len"}, obs.size(), exp_q.size());
    check({name, "_first_bad_idx"}, bad, -1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    step(1);
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < BOUND) begin
      step(1);
      n++;
    end
    check(name, int'(done_cnt >= target), 1);
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!init_done && n < 500) begin
      step(1);
      n++;
    end
    check(name, int'(init_done), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_res_n"},      int'(oled_res_n),     0);
    check({tag, "_valid"},      int'(bus.byte_valid), 0);
    check({tag, "_data"},       int'(bus.byte_data),  0);
    check({tag, "_dc"},         int'(bus.byte_dc),    0);
    check({tag, "_fb_addr"},    int'(bus.fb_addr),    0);
    check({tag, "_init_done"},  int'(init_done),      0);
    check({tag, "_frame_done"}, int'(frame_done),     0);
  endtask

  initial begin
    int ecount;
    int base;
    int n;

    rst_n = 1'b0;
    frame_req = 1'b0;
    bus.byte_ready = 1'b1;
    for (int a = 0; a < 1024; a++) mem[a] = pix(a);

    vecs[0] = '{1,  0, 0, 'h00, 0};
    vecs[1] = '{9,  0, 0, 'h00, 0};
    vecs[2] = '{10, 1, 0, 'h00, 0};
    vecs[3] = '{14, 1, 0, 'h00, 0};
    vecs[4] = '{15, 1, 1, 'hAE, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");

    rst_n = 1'b1;
    ecount = 0;
    for (int i = 0; i < 5; i++) begin
      repeat (vecs[i].cyc - ecount) @(posedge clk);
      ecount = vecs[i].cyc;
      #1;
      check($sformatf("rst_vec%0d_res_n", i),  int'(oled_res_n),     vecs[i].res_n);
      check($sformatf("rst_vec%0d_valid", i),  int'(bus.byte_valid), vecs[i].valid);
      if (vecs[i].valid != 0) begin
        check($sformatf("rst_vec%0d_data", i), int'(bus.byte_data),  vecs[i].data);
        check($sformatf("rst_vec%0d_dc", i),   int'(bus.byte_dc),    0);
      end
      check($sformatf("rst_vec%0d_init_done", i), int'(init_done), vecs[i].init_done);
    end

    wait_init("init_done_timeout");
    exp_q.delete();
    exp_init();
    check_stream("init");
    check("init_back_to_back", (obs.size() >= 25) ? obs_cyc[24] - obs_cyc[0] : -1, 24);

    // frame with serializer always ready
    obs.delete(); obs_cyc.delete();
    base = done_cnt;
    pulse_req();
    wait_done(base + 1, "f1_done_timeout");
    step(20);
    check("f1_done_pulses", done_cnt - base, 1);
    exp_q.delete();
    exp_frame();
    check_stream("f1");
    check("f1_window_back_to_back", (obs.size() >= 6) ? obs_cyc[5] - obs_cyc[0] : -1, 5);

    // frame with random backpressure
    rdy_rand = 1;
    obs.delete(); obs_cyc.delete();
    stall_viol = 0; stall_seen = 0;
    base = done_cnt;
    pulse_req();
    wait_done(base + 1, "f2_done_timeout");
    step(20);
    check("f2_done_pulses", done_cnt - base, 1);
    exp_q.delete();
    exp_frame();
    check_stream("f2");
    check("f2_stall_stable", stall_viol, 0);
    check("f2_stalls_seen", int'(stall_seen > 0), 1);

    // repeated requests mid-frame plus one coincident with frame_done
    obs.delete(); obs_cyc.delete();
    data_cnt = 0;
    base = done_cnt;
    pulse_req();
    n = 0;
    while (data_cnt < 100 && n < BOUND) begin step(1); n++; end
    check("f3_reach_byte100", int'(data_cnt >= 100), 1);
    pulse_req();
    step(50);
    pulse_req();
    n = 0;
    while (!frame_done && n < BOUND) begin step(1); n++; end
    check("f3_first_done_seen", int'(frame_done), 1);
    pulse_req();
    wait_done(base + 2, "f3_second_done_timeout");
    step(300);
    check("f3_done_pulses", done_cnt - base, 2);
    exp_q.delete();
    exp_frame();
    exp_frame();
    check_stream("f3");
    check("f3_stall_stable", stall_viol, 0);
    rdy_rand = 0;
    step(2);

    // asynchronous reset in the middle of the data phase
    obs.delete(); obs_cyc.delete();
    data_cnt = 0;
    pulse_req();
    n = 0;
    while (data_cnt < 300 && n < BOUND) begin step(1); n++; end
    check("rst_reach_byte300", int'(data_cnt >= 300), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    obs.delete(); obs_cyc.delete();
    repeat (RST_CYC - 1) @(posedge clk);
    #1;
    check("rerun_res_n_low", int'(oled_res_n), 0);
    step(1);
    check("rerun_res_n_high", int'(oled_res_n), 1);
    wait_init("rerun_init_timeout");
    step(100);
    exp_q.delete();
    exp_init();
    check_stream("rerun_init");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
